cf_fft_reorder_buffer: RTL and testbench

Parametrised ping-pong reorder buffer for the streaming FFT pipeline. It captures one frame of 2^LOG2_N complex samples into one bank while the previously captured frame is read out of the other bank. Read order is selectable per frame: natural, bit-reversed, or butterfly-pair order for a configurable stage. It generalises the fixed 1024-point, 16-bit stage buffer, and adds run-time mode, frame-error detection and explicit output framing.

---
 rtl/cf_fft_pkg.sv | 51 +++++
 rtl/cf_fft_dpram.sv | 27 ++
 rtl/cf_fft_reorder_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_cf_fft_reorder_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cf_fft_pkg.sv
// Shared definitions for the FFT reorder buffer: read-order modes, FSM encodings
// and the address permutation helpers (computed at full 12-bit width, callers truncate).
package cf_fft_pkg;

    localparam int MAX_LOG2_N = 12;

    localparam logic [1:0] MODE_NAT  = 2'b00;
    localparam logic [1:0] MODE_BREV = 2'b01;
    localparam logic [1:0] MODE_PAIR = 2'b10;

    localparam logic [0:0] WR_IDLE  = 1'b0;
    localparam logic [0:0] WR_WRITE = 1'b1;
    localparam logic [0:0] RD_IDLE  = 1'b0;
    localparam logic [0:0] RD_READ  = 1'b1;

    function automatic logic [MAX_LOG2_N-1:0] bitrev(
        input logic [MAX_LOG2_N-1:0] idx,
        input int                    log2n
    );
        logic [MAX_LOG2_N-1:0] r;
        logic [3:0]            src;
        r = '0;
        for (int i = 0; i < MAX_LOG2_N; i++) begin
            src = (i < log2n) ? 4'(log2n - 1 - i) : 4'd0;
            if (i < log2n) r[i] = idx[src];
        end
        return r;
    endfunction

    // Butterfly pair order: the counter LSB selects the partner at bit p,
    // the bits below p shift down by one, bits above p are unchanged.
    function automatic logic [MAX_LOG2_N-1:0] pair_perm(
        input logic [MAX_LOG2_N-1:0] idx,
        input int                    log2n,
        input int                    stage
    );
        logic [MAX_LOG2_N-1:0] r;
        logic [MAX_LOG2_N:0]   ext;
        int                    p;
        p   = log2n - 1 - stage;
        ext = {1'b0, idx};
        r   = '0;
        for (int i = 0; i < MAX_LOG2_N; i++) begin
            if (i < p)       r[i] = ext[i+1];
            else if (i == p) r[i] = idx[0];
            else             r[i] = idx[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/cf_fft_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, both gated by ce.
module cf_fft_dpram #(
    parameter int AW = 4,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) mem[waddr] <= wdata;
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cf_fft_reorder_buffer.sv
// Ping-pong frame reorder buffer: one bank is written in natural order while the
// other is read out in natural, bit-reversed or butterfly-pair order.
module cf_fft_reorder_buffer
    import cf_fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 10,
    parameter int STAGE  = 0
) (
    input  logic              clock_c,
    input  logic              reset_c,
    input  logic              ce,
    input  logic              in_start,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic [1:0]        mode,
    output logic              out_valid,
    output logic              out_start,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic              frame_err
);

    localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};
    localparam logic [LOG2_N-1:0] CNT_ONE  = LOG2_N'(1);

    logic [0:0]          wr_state_q, wr_state_d;
    logic [LOG2_N-1:0]   wr_cnt_q, wr_cnt_d;
    logic                wr_bank_q, wr_bank_d;
    logic [1:0]          full_q, full_d;
    logic [0:0]          rd_state_q, rd_state_d;
    logic [LOG2_N-1:0]   rd_cnt_q, rd_cnt_d;
    logic                rd_bank_q, rd_bank_d;
    logic [1:0]          rd_mode_q, rd_mode_d;
    logic                v1_q, v1_d;
    logic                s1_q, s1_d;
    logic                out_valid_q, out_valid_d;
    logic                out_start_q, out_start_d;
    logic [DATA_W-1:0]   out_re_q, out_re_d;
    logic [DATA_W-1:0]   out_im_q, out_im_d;
    logic                frame_err_q, frame_err_d;

    logic                we;
    logic [LOG2_N-1:0]   waddr_lo;
    logic                wr_done;
    logic                rd_en;
    logic                rd_first;
    logic                rd_done;
    logic [LOG2_N-1:0]   rd_idx;
    logic [1:0]          rd_order;
    logic [LOG2_N-1:0]   raddr_lo;
    logic [2*DATA_W-1:0] ram_rdata;

    // Writer: in_start always restarts at address 0; it is an error only mid-frame.
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        we          = 1'b0;
        waddr_lo    = '0;
        wr_done     = 1'b0;
        frame_err_d = 1'b0;
        if (in_start) begin
            frame_err_d = (wr_state_q == WR_WRITE) && (wr_cnt_q != '0);
            we          = 1'b1;
            wr_cnt_d    = CNT_ONE;
            wr_state_d  = WR_WRITE;
        end else if (wr_state_q == WR_WRITE) begin
            if (wr_cnt_q != '0) begin
                we       = 1'b1;
                waddr_lo = wr_cnt_q;
                if (wr_cnt_q == CNT_LAST) begin
                    wr_done   = 1'b1;
                    wr_cnt_d  = '0;
                    wr_bank_d = ~wr_bank_q;
                end else begin
                    wr_cnt_d = wr_cnt_q + CNT_ONE;
                end
            end else begin
                wr_state_d = WR_IDLE;
            end
        end
    end

    // Reader: the first address is issued from IDLE with the live mode, which is then held.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_bank_d  = rd_bank_q;
        rd_mode_d  = rd_mode_q;
        rd_en      = 1'b0;
        rd_first   = 1'b0;
        rd_done    = 1'b0;
        rd_idx     = rd_cnt_q;
        rd_order   = rd_mode_q;
        if (rd_state_q == RD_IDLE) begin
            rd_idx = '0;
            if (full_q[rd_bank_q]) begin
                rd_en      = 1'b1;
                rd_first   = 1'b1;
                rd_order   = mode;
                rd_mode_d  = mode;
                rd_cnt_d   = CNT_ONE;
                rd_state_d = RD_READ;
            end
        end else begin
            rd_en = 1'b1;
            if (rd_cnt_q == CNT_LAST) begin
                rd_done    = 1'b1;
                rd_cnt_d   = '0;
                rd_bank_d  = ~rd_bank_q;
                rd_state_d = RD_IDLE;
            end else begin
                rd_cnt_d = rd_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        case (rd_order)
            MODE_BREV: raddr_lo = LOG2_N'(bitrev(MAX_LOG2_N'(rd_idx), LOG2_N));
            MODE_PAIR: raddr_lo = LOG2_N'(pair_perm(MAX_LOG2_N'(rd_idx), LOG2_N, STAGE));
            default:   raddr_lo = rd_idx;
        endcase
    end

    always_comb begin
        full_d = full_q;
        if (rd_done) full_d[rd_bank_q] = 1'b0;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
    end

    // Two-stage output: RAM read register, then the output register.
    always_comb begin
        v1_d        = rd_en;
        s1_d        = rd_first;
        out_valid_d = v1_q;
        out_start_d = s1_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        if (v1_q) begin
            out_re_d = ram_rdata[2*DATA_W-1:DATA_W];
            out_im_d = ram_rdata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock_c or posedge reset_c) begin
        if (reset_c) begin
            wr_state_q  <= WR_IDLE;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            rd_state_q  <= RD_IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_mode_q   <= MODE_NAT;
            v1_q        <= 1'b0;
            s1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            frame_err_q <= 1'b0;
        end else if (ce) begin
            wr_state_q  <= wr_state_d;
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            rd_state_q  <= rd_state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_mode_q   <= rd_mode_d;
            v1_q        <= v1_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_start_q <= out_start_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            frame_err_q <= frame_err_d;
        end
    end

    cf_fft_dpram #(
        .AW (LOG2_N + 1),
        .DW (2 * DATA_W)
    ) u_ram (
        .clk   (clock_c),
        .ce    (ce),
        .we    (we),
        .waddr ({wr_bank_q, waddr_lo}),
        .wdata ({in_re, in_im}),
        .raddr ({rd_bank_q, raddr_lo}),
        .rdata (ram_rdata)
    );

    assign out_valid = out_valid_q;
    assign out_start = out_start_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cf_fft_reorder_buffer.sv
// Bench for cf_fft_reorder_buffer (N=8): two instances (STAGE 0 and 1) share stimulus
// and are checked against a frame-level reference model with cycle-indexed expectations.
module tb_cf_fft_reorder_buffer;

    localparam int DATA_W = 16;
    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;
    localparam int DEPTH  = 8192;

    logic              clk = 1'b0;
    logic              rst;
    logic              ce;
    logic              in_start;
    logic [DATA_W-1:0] in_re, in_im;
    logic [1:0]        mode;
    logic [1:0]        cur_mode;

    logic              out_valid0, out_start0, frame_err0;
    logic [DATA_W-1:0] out_re0, out_im0;
    logic              out_valid1, out_start1, frame_err1;
    logic [DATA_W-1:0] out_re1, out_im1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state
    bit                  wr_active;
    int                  wr_cnt;
    logic [2*DATA_W-1:0] cur_buf [0:N-1];
    logic [2*DATA_W-1:0] pend_q [$];
    int                  pend_ready_q [$];
    int                  rd_free;
    bit                  exp_valid [0:DEPTH-1];
    bit                  exp_start [0:DEPTH-1];
    bit                  exp_err   [0:DEPTH-1];
    logic [2*DATA_W-1:0] exp_d0    [0:DEPTH-1];
    logic [2*DATA_W-1:0] exp_d1    [0:DEPTH-1];

    cf_fft_reorder_buffer #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .STAGE(0)) u_dut0 (
        .clock_c(clk), .reset_c(rst), .ce(ce), .in_start(in_start),
        .in_re(in_re), .in_im(in_im), .mode(mode),
        .out_valid(out_valid0), .out_start(out_start0),
        .out_re(out_re0), .out_im(out_im0), .frame_err(frame_err0)
    );

    cf_fft_reorder_buffer #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .STAGE(1)) u_dut1 (
        .clock_c(clk), .reset_c(rst), .ce(ce), .in_start(in_start),
        .in_re(in_re), .in_im(in_im), .mode(mode),
        .out_valid(out_valid1), .out_start(out_start1),
        .out_re(out_re1), .out_im(out_im1), .frame_err(frame_err1)
    );

    // Clock / reset / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (ce cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read position k of a frame maps to this sample index
    function automatic int order_of(input int k, input logic [1:0] md, input int stage);
        int r, t, d;
        if (md == 2'b01) begin
            r = 0;
            t = k;
            for (int b = 0; b < LOG2_N; b++) begin
                r = r * 2 + (t % 2);
                t = t / 2;
            end
            return r;
        end else if (md == 2'b10) begin
            d = N >> (stage + 1);
            return (k / (2 * d)) * (2 * d) + ((k % (2 * d)) / 2) + (k % 2) * d;
        end
        return k;
    endfunction

    task automatic model_clear();
        wr_active = 1'b0;
        wr_cnt    = 0;
        rd_free   = 0;
        pend_q.delete();
        pend_ready_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            exp_valid[i] = 1'b0;
            exp_start[i] = 1'b0;
            exp_err[i]   = 1'b0;
        end
    endtask

    // One ce cycle of the model at cycle index c
    task automatic model_step(input int c, input logic st, input logic [DATA_W-1:0] re,
                              input logic [DATA_W-1:0] im, input logic [1:0] md);
        logic [2*DATA_W-1:0] f [0:N-1];
        if (st) begin
            if (wr_active && wr_cnt != 0) exp_err[c+1] = 1'b1;
            cur_buf[0] = {re, im};
            wr_cnt     = 1;
            wr_active  = 1'b1;
        end else if (wr_active && wr_cnt != 0) begin
            cur_buf[wr_cnt] = {re, im};
            wr_cnt++;
            if (wr_cnt == N) begin
                for (int i = 0; i < N; i++) pend_q.push_back(cur_buf[i]);
                pend_ready_q.push_back(c + 1);
                wr_cnt = 0;
            end
        end else begin
            wr_active = 1'b0;
        end
        if (pend_ready_q.size() > 0 && pend_ready_q[0] <= c && c >= rd_free) begin
            void'(pend_ready_q.pop_front());
            for (int i = 0; i < N; i++) f[i] = pend_q.pop_front();
            for (int k = 0; k < N; k++) begin
                exp_valid[c+2+k] = 1'b1;
                exp_start[c+2+k] = (k == 0);
                exp_d0[c+2+k]    = f[order_of(k, md, 0)];
                exp_d1[c+2+k]    = f[order_of(k, md, 1)];
            end
            rd_free = c + N;
        end
    endtask

    // Scoreboard: step on every ce edge, compare just after it
    always @(posedge clk) begin
        if (rst) begin
            model_clear();
        end else if (ce) begin
            model_step(cyc, in_start, in_re, in_im, mode);
            #1;
            check_eq("valid0", 32'(out_valid0), 32'(exp_valid[cyc+1]));
            check_eq("valid1", 32'(out_valid1), 32'(exp_valid[cyc+1]));
            check_eq("start0", 32'(out_start0), 32'(exp_start[cyc+1]));
            check_eq("start1", 32'(out_start1), 32'(exp_start[cyc+1]));
            check_eq("err0",   32'(frame_err0), 32'(exp_err[cyc+1]));
            check_eq("err1",   32'(frame_err1), 32'(exp_err[cyc+1]));
            if (exp_valid[cyc+1]) begin
                check_eq("data0", {out_re0, out_im0}, exp_d0[cyc+1]);
                check_eq("data1", {out_re1, out_im1}, exp_d1[cyc+1]);
            end
            cyc++;
        end
    end

    // Driver tasks: one accepted (ce=1) sample per call, junk on ce=0 cycles
    task automatic drive_sample(input logic st, input logic [DATA_W-1:0] re,
                                input logic [DATA_W-1:0] im, input int ce_pct);
        do begin
            @(negedge clk);
            mode = cur_mode;
            ce   = ($urandom_range(99) < ce_pct);
            if (ce) begin
                in_start = st;
                in_re    = re;
                in_im    = im;
            end else begin
                in_start = 1'($urandom_range(1));
                in_re    = DATA_W'($urandom);
                in_im    = DATA_W'($urandom);
            end
        end while (!ce);
    endtask

    task automatic idle(input int n, input int ce_pct);
        for (int i = 0; i < n; i++)
            drive_sample(1'b0, DATA_W'($urandom), DATA_W'($urandom), ce_pct);
    endtask

    task automatic send_frame(input int base, input bit rnd, input int ce_pct,
                              input int sw_at, input logic [1:0] sw_mode);
        logic [DATA_W-1:0] re;
        for (int i = 0; i < N; i++) begin
            if (i == sw_at) cur_mode = sw_mode;
            re = rnd ? DATA_W'($urandom) : DATA_W'(base + i);
            drive_sample(i == 0, re, rnd ? DATA_W'($urandom) : -re, ce_pct);
        end
    endtask

    initial begin
        rst      = 1'b1;
        ce       = 1'b0;
        in_start = 1'b0;
        in_re    = '0;
        in_im    = '0;
        mode     = 2'b00;
        cur_mode = 2'b00;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(out_valid0 | out_valid1), 32'd0);
        check_eq("rst_start", 32'(out_start0 | out_start1), 32'd0);
        check_eq("rst_err",   32'(frame_err0 | frame_err1), 32'd0);
        check_eq("rst_data",  {out_re0 | out_re1, out_im0 | out_im1}, 32'd0);
        rst = 1'b0;

        // Natural, bit-reversed and pair order, single frames
        cur_mode = 2'b00; send_frame(0, 1'b0, 100, -1, 2'b00); idle(14, 100);
        cur_mode = 2'b01; send_frame(0, 1'b0, 100, -1, 2'b00); idle(14, 100);
        cur_mode = 2'b10; send_frame(0, 1'b0, 100, -1, 2'b00); idle(14, 100);

        // Three back-to-back frames, mode switched while frame 1 is being read
        cur_mode = 2'b00;
        send_frame(0,  1'b0, 100, -1, 2'b00);
        send_frame(8,  1'b0, 100,  3, 2'b01);
        send_frame(16, 1'b0, 100, -1, 2'b00);
        idle(20, 100);

        // Restart at wr_cnt=5: error pulse, partial frame dropped
        cur_mode = 2'b00;
        for (int i = 0; i < 5; i++) drive_sample(i == 0, DATA_W'(200 + i), DATA_W'(0), 100);
        send_frame(100, 1'b0, 100, -1, 2'b00);
        idle(14, 100);

        // Same reference frames with 50% clock enable
        cur_mode = 2'b01; send_frame(0, 1'b0, 50, -1, 2'b00); idle(14, 50);
        cur_mode = 2'b10; send_frame(0, 1'b0, 50, -1, 2'b00); idle(14, 50);

        // Random frames, modes (including 11), gaps and ce
        for (int f = 0; f < 14; f++) begin
            cur_mode = 2'($urandom_range(3));
            send_frame(0, 1'b1, ($urandom_range(1) != 0) ? 100 : 50, -1, 2'b00);
            idle($urandom_range(3), 50);
        end
        idle(20, 100);

        // Asynchronous reset during readout
        cur_mode = 2'b10;
        send_frame(50, 1'b0, 100, -1, 2'b00);
        for (int k = 0; k < 40 && !out_valid0; k++) @(negedge clk);
        check_eq("wait_valid", 32'(out_valid0), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", 32'(out_valid0 | out_valid1), 32'd0);
        check_eq("arst_start", 32'(out_start0 | out_start1), 32'd0);
        check_eq("arst_err",   32'(frame_err0 | frame_err1), 32'd0);
        check_eq("arst_data",  {out_re0 | out_re1, out_im0 | out_im1}, 32'd0);
        @(negedge clk);
        ce       = 1'b1;
        in_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(20, 100);
        cur_mode = 2'b01;
        send_frame(60, 1'b0, 100, -1, 2'b00);
        idle(14, 100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
